// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the cnn1d datapath.
// Samples are two's complement; cnn1d_max keeps its first argument on ties.
package cnn1d_pkg;

  localparam int DATA_WIDTH = 12;

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  function automatic data_t cnn1d_max(input data_t a, input data_t b);
    if (b > a) begin
      return b;
    end else begin
      return a;
    end
  endfunction

endpackage

// File: rtl/maxpool1d_checker.sv
// Protocol properties for the maxpool1d output handshake.
// Bound inside the top so every instance carries them.
module maxpool1d_checker
  import cnn1d_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  input logic                  in_ready,
  input logic                  out_valid,
  input logic                  out_ready,
  input logic [DATA_WIDTH-1:0] out_data,
  input logic                  out_last
);

  a_ready_rule: assert property (@(posedge clk) disable iff (rst)
    in_ready == (!out_valid || out_ready));

  // A stalled result must not move or vanish until it is taken.
  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

endmodule

// File: rtl/maxpool1d.sv
// Streaming non-overlapping 1-D max pooling with ready/valid on both sides.
// A frame-end sample always closes the current window, even a partial one.
module maxpool1d
  import cnn1d_pkg::*;
#(
  parameter int POOL_SIZE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int CNT_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  data_t            max_q_r;
  data_t            out_data_r;
  logic             out_valid_r;
  logic             out_last_r;

  data_t            in_sample_s;
  data_t            candidate_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             pop_s;
  logic             close_s;

  assign in_sample_s = data_t'(in_data);

  // Handshake decode and running-maximum candidate for this cycle
  always_comb begin
    in_ready_s = !out_valid_r || out_ready;
    accept_s   = in_valid && in_ready_s;
    pop_s      = out_valid_r && out_ready;
    if (cnt_r == CNT_ZERO) begin
      candidate_s = in_sample_s;
    end else begin
      candidate_s = cnn1d_max(max_q_r, in_sample_s);
    end
    if (accept_s && ((cnt_r == CNT_LAST) || in_last)) begin
      close_s = 1'b1;
    end else begin
      close_s = 1'b0;
    end
  end

  // Window state and the single output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= CNT_ZERO;
      max_q_r     <= data_t'(0);
      out_data_r  <= data_t'(0);
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (accept_s) begin
      if (close_s) begin
        // Reload even when popping this same cycle: no bubble.
        out_data_r  <= candidate_s;
        out_last_r  <= in_last;
        out_valid_r <= 1'b1;
        cnt_r       <= CNT_ZERO;
      end else begin
        max_q_r <= candidate_s;
        cnt_r   <= cnt_r + CNT_ONE;
        if (pop_s) begin
          out_valid_r <= 1'b0;
        end
      end
    end else if (pop_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;

  maxpool1d_checker u_checker (
    .clk       (clk),
    .rst       (rst),
    .in_ready  (in_ready_s),
    .out_valid (out_valid_r),
    .out_ready (out_ready),
    .out_data  (out_data_r),
    .out_last  (out_last_r)
  );

endmodule

// File: tb/tb_maxpool1d.sv
// Scoreboard bench: two instances (POOL_SIZE 2 and 3) driven by directed and random
// traffic; a window-list reference model predicts every pooled result.
module tb_maxpool1d;

  logic        clk;
  logic        rst;
  logic [11:0] in_data   [2];
  logic        in_valid  [2];
  logic        in_last   [2];
  logic        in_ready  [2];
  logic [11:0] out_data  [2];
  logic        out_valid [2];
  logic        out_last  [2];
  logic        out_ready [2];

  int checks = 0;
  int errors = 0;

  int                 psz [2] = '{2, 3};
  logic signed [11:0] win  [2][$];
  logic [12:0]        expq [2][$];
  logic               held [2];
  logic [12:0]        prev_out [2];
  logic [12:0]        last_out [2];
  int                 nout [2];

  maxpool1d #(.POOL_SIZE(2)) dut0 (
    .clk(clk), .rst(rst),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_last(out_last[0]), .out_ready(out_ready[0])
  );

  maxpool1d #(.POOL_SIZE(3)) dut1 (
    .clk(clk), .rst(rst),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_last(out_last[1]), .out_ready(out_ready[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset discards any partial window and pending result in the model.
  always @(posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      win[k].delete();
      expq[k].delete();
      held[k] = 1'b0;
    end
  end

  // Monitor: handshakes occur at the next rising edge with the values seen here.
  always @(negedge clk) begin
    logic [12:0]        e;
    logic signed [11:0] m;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ((out_valid[k] ? 1 : 0) != expq[k].size()) begin
          errors++;
          $display("FAIL occupancy[%0d] out_valid=%0b expected_pending=%0d", k, out_valid[k], expq[k].size());
        end
        checks++;
        if (in_ready[k] !== (!out_valid[k] || out_ready[k])) begin
          errors++;
          $display("FAIL in_ready[%0d] got=%0b want=%0b", k, in_ready[k], !out_valid[k] || out_ready[k]);
        end
        if (held[k]) begin
          checks++;
          if ({out_last[k], out_data[k]} !== prev_out[k]) begin
            errors++;
            $display("FAIL stall_hold[%0d] got=%h want=%h", k, {out_last[k], out_data[k]}, prev_out[k]);
          end
        end
        held[k]     = out_valid[k] && !out_ready[k];
        prev_out[k] = {out_last[k], out_data[k]};
        if (out_valid[k] && out_ready[k] && expq[k].size() > 0) begin
          e = expq[k].pop_front();
          checks++;
          if ({out_last[k], out_data[k]} !== e) begin
            errors++;
            $display("FAIL result[%0d] got last=%0b data=%h want last=%0b data=%h",
                     k, out_last[k], out_data[k], e[12], e[11:0]);
          end
          last_out[k] = {out_last[k], out_data[k]};
          nout[k]++;
        end
        if (in_valid[k] && in_ready[k]) begin
          win[k].push_back($signed(in_data[k]));
          if (win[k].size() == psz[k] || in_last[k]) begin
            m = win[k][0];
            foreach (win[k][i]) begin
              if (win[k][i] > m) m = win[k][i];
            end
            expq[k].push_back({in_last[k], m});
            win[k].delete();
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted; called just after a rising edge.
  task automatic send(input int k, input logic [11:0] d, input logic l, output int retries);
    logic taken;
    retries = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_last[k]  = l;
    forever begin
      @(negedge clk);
      taken = in_ready[k];
      @(posedge clk);
      #1;
      if (taken) break;
      retries++;
      if (retries > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout[%0d] data=%h", k, d);
        break;
      end
    end
    in_valid[k] = 1'b0;
  endtask

  initial begin
    int r;
    int rsum;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data[k] = 12'h000; in_valid[k] = 1'b0; in_last[k] = 1'b0; out_ready[k] = 1'b1;
      held[k] = 1'b0; prev_out[k] = 13'h0; last_out[k] = 13'h0; nout[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_out_valid", 32'(out_valid[k]), 32'd0);
      chk("reset_out_data", 32'(out_data[k]), 32'd0);
      chk("reset_out_last", 32'(out_last[k]), 32'd0);
    end
    rst = 1'b0;
    idle(1);

    // Back-to-back stream at full throughput.
    rsum = 0;
    send(0, 12'd5, 1'b0, r); rsum += r;
    send(0, 12'd3, 1'b0, r); rsum += r;
    send(0, 12'd7, 1'b0, r); rsum += r;
    send(0, 12'd9, 1'b0, r); rsum += r;
    chk("stream_no_stall", 32'(rsum), 32'd0);
    idle(2);
    chk("stream_last_result", 32'(last_out[0]), 32'h009);
    chk("stream_count", 32'(nout[0]), 32'd2);

    // Signed comparison.
    send(0, 12'hFFF, 1'b0, r);
    send(0, 12'h800, 1'b0, r);
    idle(2);
    chk("signed_neg", 32'(last_out[0]), 32'h0FFF);
    send(0, 12'h800, 1'b0, r);
    send(0, 12'h001, 1'b0, r);
    idle(2);
    chk("signed_mixed", 32'(last_out[0]), 32'h0001);

    // Frame end closes a short window; next frame starts fresh.
    send(1, 12'd4, 1'b0, r);
    send(1, 12'd8, 1'b1, r);
    idle(2);
    chk("frame_end_partial", 32'(last_out[1]), 32'h1008);
    send(1, 12'd1, 1'b0, r);
    send(1, 12'd2, 1'b0, r);
    send(1, 12'd6, 1'b0, r);
    idle(2);
    chk("frame_restart", 32'(last_out[1]), 32'h0006);

    // Backpressure with result 9 pending.
    out_ready[0] = 1'b0;
    send(0, 12'd8, 1'b0, r);
    send(0, 12'd9, 1'b0, r);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_out_data", 32'(out_data[0]), 32'd9);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    send(0, 12'd4, 1'b0, r);
    chk("bp_resume", 32'(r), 32'd0);
    send(0, 12'd2, 1'b0, r);
    idle(2);
    chk("bp_after", 32'(last_out[0]), 32'h0004);

    // Asynchronous reset with a stalled result and a partial window.
    out_ready[0] = 1'b0;
    send(0, 12'd6, 1'b0, r);
    send(0, 12'd6, 1'b0, r);
    send(1, 12'd5, 1'b0, r);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid0", 32'(out_valid[0]), 32'd0);
    chk("async_rst_data0", 32'(out_data[0]), 32'd0);
    chk("async_rst_valid1", 32'(out_valid[1]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready[0] = 1'b1;
    idle(1);
    send(0, 12'd2, 1'b0, r);
    send(0, 12'd1, 1'b0, r);
    send(1, 12'd2, 1'b0, r);
    send(1, 12'd1, 1'b1, r);
    idle(2);
    chk("post_rst_pool2", 32'(last_out[0]), 32'h0002);
    chk("post_rst_pool3", 32'(last_out[1]), 32'h1002);

    // Random traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        in_data[k]   = 12'($urandom);
        in_last[k]   = ($urandom_range(0, 6) == 0);
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
    idle(4);
    chk("drain0", 32'(expq[0].size()), 32'd0);
    chk("drain1", 32'(expq[1].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
